// File: rtl/udp_rx_parser.sv
// Receive-side Ethernet/IPv4/UDP header parser: strips headers, forwards payload words,
// and detects ARP requests addressed to this node.
module udp_rx_parser #(
    parameter int CNT_WIDTH      = 16,
    parameter bit CHECK_UDP_PORT = 1'b1,
    parameter bit ARP_ENABLE     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_tvalid,
    input  logic [63:0]          rx_tdata,
    input  logic                 rx_tlast,
    input  logic                 rx_tuser,
    output logic                 rx_tready,
    input  logic [47:0]          fpga_mac_adr,
    input  logic [31:0]          fpga_ip_adr,
    input  logic [15:0]          fpga_udp_port,
    output logic                 out_valid,
    output logic [63:0]          out_data,
    input  logic                 out_ready,
    output logic                 arp_trigger,
    output logic [47:0]          arp_sender_mac,
    output logic [31:0]          arp_sender_ip,
    output logic [CNT_WIDTH-1:0] rx_pkt_count,
    output logic [CNT_WIDTH-1:0] rx_drop_count,
    output logic [3:0]           sm_state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        HDR1     = 4'd1,
        IP2      = 4'd2,
        IP3      = 4'd3,
        UDP0     = 4'd4,
        UDP1     = 4'd5,
        PAYLOAD  = 4'd6,
        ARP2     = 4'd7,
        ARP3     = 4'd8,
        ARP4     = 4'd9,
        ARP5     = 4'd10,
        ARP_WAIT = 4'd11,
        DROP     = 4'd12
    } state_e;

    state_e                state_q;
    logic                  out_valid_q;
    logic [63:0]           out_data_q;
    logic                  arp_trigger_q;
    logic [47:0]           arp_mac_q;
    logic [31:0]           arp_ip_q;
    logic [47:0]           sha_shadow_q;
    logic [31:0]           spa_shadow_q;
    logic [15:0]           ipda_hi_q;
    logic [15:0]           sha_hi_q;
    logic [15:0]           tpa_hi_q;
    logic                  arp_match_q;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic                  xfer;
    logic                  port_ok;

    assign rx_tready  = (state_q == PAYLOAD) ? (~out_valid_q | out_ready) : 1'b1;
    assign xfer       = rx_tvalid & rx_tready;
    assign port_ok    = !CHECK_UDP_PORT || (rx_tdata[31:16] == fpga_udp_port);
    assign pkt_cnt_d  = (&pkt_cnt_q)  ? pkt_cnt_q  : pkt_cnt_q  + 1'b1;
    assign drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            arp_trigger_q <= 1'b0;
            arp_mac_q     <= '0;
            arp_ip_q      <= '0;
            sha_shadow_q  <= '0;
            spa_shadow_q  <= '0;
            ipda_hi_q     <= '0;
            sha_hi_q      <= '0;
            tpa_hi_q      <= '0;
            arp_match_q   <= 1'b0;
            pkt_cnt_q     <= '0;
            drop_cnt_q    <= '0;
        end else begin
            arp_trigger_q <= 1'b0;
            if (state_q == PAYLOAD && xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= rx_tdata;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (xfer) begin
                // A tlast in any header state is a truncated frame: count it and resync.
                if (rx_tlast && state_q != PAYLOAD && state_q != ARP_WAIT) begin
                    state_q    <= IDLE;
                    drop_cnt_q <= drop_cnt_d;
                end else begin
                    case (state_q)
                        IDLE: state_q <= (rx_tdata[63:16] == fpga_mac_adr ||
                                          rx_tdata[63:16] == 48'hFFFF_FFFF_FFFF) ? HDR1 : DROP;
                        HDR1: begin
                            if (rx_tdata[31:16] == 16'h0800 && rx_tdata[15:8] == 8'h45)
                                state_q <= IP2;
                            else if (rx_tdata[31:16] == 16'h0806 && ARP_ENABLE)
                                state_q <= ARP2;
                            else
                                state_q <= DROP;
                        end
                        IP2:  state_q <= (rx_tdata[7:0] == 8'h11) ? IP3 : DROP;
                        IP3: begin
                            ipda_hi_q <= rx_tdata[15:0];
                            state_q   <= UDP0;
                        end
                        UDP0: state_q <= ({ipda_hi_q, rx_tdata[63:48]} == fpga_ip_adr && port_ok)
                                         ? UDP1 : DROP;
                        UDP1: state_q <= PAYLOAD;
                        PAYLOAD: begin
                            if (rx_tlast) begin
                                state_q <= IDLE;
                                if (rx_tuser) drop_cnt_q <= drop_cnt_d;
                                else          pkt_cnt_q  <= pkt_cnt_d;
                            end
                        end
                        ARP2: begin
                            sha_hi_q <= rx_tdata[15:0];
                            state_q  <= (rx_tdata[31:16] == 16'h0001) ? ARP3 : DROP;
                        end
                        ARP3: begin
                            sha_shadow_q <= {sha_hi_q, rx_tdata[63:32]};
                            spa_shadow_q <= rx_tdata[31:0];
                            state_q      <= ARP4;
                        end
                        ARP4: begin
                            tpa_hi_q <= rx_tdata[15:0];
                            state_q  <= ARP5;
                        end
                        ARP5: begin
                            arp_match_q <= ({tpa_hi_q, rx_tdata[63:48]} == fpga_ip_adr);
                            state_q     <= ARP_WAIT;
                        end
                        ARP_WAIT: begin
                            if (rx_tlast) begin
                                state_q     <= IDLE;
                                arp_match_q <= 1'b0;
                                if (arp_match_q && !rx_tuser) begin
                                    arp_mac_q     <= sha_shadow_q;
                                    arp_ip_q      <= spa_shadow_q;
                                    arp_trigger_q <= 1'b1;
                                end else begin
                                    drop_cnt_q <= drop_cnt_d;
                                end
                            end
                        end
                        DROP: begin
                            if (rx_tlast) begin
                                state_q    <= IDLE;
                                drop_cnt_q <= drop_cnt_d;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign arp_trigger    = arp_trigger_q;
    assign arp_sender_mac = arp_mac_q;
    assign arp_sender_ip  = arp_ip_q;
    assign rx_pkt_count   = pkt_cnt_q;
    assign rx_drop_count  = drop_cnt_q;
    assign sm_state       = state_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed bench for udp_rx_parser: a port-checking instance plus a port-agnostic
// instance fed with exactly the same accepted words.
module tb_udp_rx_parser;

    localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SA   = 48'h0A_0B_0C_0D_0E_0F;
    localparam logic [31:0] IP   = 32'hC0A8_0001;
    localparam logic [15:0] PORT = 16'h1234;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_tvalid = 1'b0;
    logic [63:0] rx_tdata = '0;
    logic        rx_tlast = 1'b0;
    logic        rx_tuser = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_ready2 = 1'b1;

    logic        rx_tready, out_valid, arp_trigger;
    logic [63:0] out_data;
    logic [47:0] arp_sender_mac;
    logic [31:0] arp_sender_ip;
    logic [15:0] rx_pkt_count, rx_drop_count;
    logic [3:0]  sm_state;

    logic        rx_tvalid2, rx_tready2, out_valid2, arp_trigger2;
    logic [63:0] out_data2;
    logic [47:0] arp_sender_mac2;
    logic [31:0] arp_sender_ip2;
    logic [15:0] rx_pkt_count2, rx_drop_count2;
    logic [3:0]  sm_state2;

    assign rx_tvalid2 = rx_tvalid & rx_tready;

    always #5 clk = ~clk;

    udp_rx_parser #(.CNT_WIDTH(16), .CHECK_UDP_PORT(1'b1), .ARP_ENABLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata),
        .rx_tlast(rx_tlast), .rx_tuser(rx_tuser), .rx_tready(rx_tready),
        .fpga_mac_adr(MAC), .fpga_ip_adr(IP), .fpga_udp_port(PORT),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .arp_trigger(arp_trigger), .arp_sender_mac(arp_sender_mac), .arp_sender_ip(arp_sender_ip),
        .rx_pkt_count(rx_pkt_count), .rx_drop_count(rx_drop_count), .sm_state(sm_state)
    );

    udp_rx_parser #(.CNT_WIDTH(16), .CHECK_UDP_PORT(1'b0), .ARP_ENABLE(1'b1)) dut_np (
        .clk(clk), .rst_n(rst_n), .rx_tvalid(rx_tvalid2), .rx_tdata(rx_tdata),
        .rx_tlast(rx_tlast), .rx_tuser(rx_tuser), .rx_tready(rx_tready2),
        .fpga_mac_adr(MAC), .fpga_ip_adr(IP), .fpga_udp_port(PORT),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
        .arp_trigger(arp_trigger2), .arp_sender_mac(arp_sender_mac2), .arp_sender_ip(arp_sender_ip2),
        .rx_pkt_count(rx_pkt_count2), .rx_drop_count(rx_drop_count2), .sm_state(sm_state2)
    );

    int checks = 0;
    int errors = 0;
    int arp_pulses = 0;
    logic [63:0] cap1[$];
    logic [63:0] cap2[$];

    logic [63:0] frm[0:63];
    logic        frm_last[0:63];
    logic        frm_user[0:63];
    int          nw = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) cap1.push_back(out_data);
            if (out_valid2 && out_ready2) cap2.push_back(out_data2);
            if (arp_trigger) arp_pulses++;
        end
    end

    task automatic push(input logic [63:0] w);
        frm[nw] = w; frm_last[nw] = 1'b0; frm_user[nw] = 1'b0; nw++;
    endtask

    // nkeep > 0 truncates the frame after that many words.
    task automatic add_udp(input logic [15:0] dp, input logic [63:0] base, input int npay,
                           input logic user, input int nkeep);
        int s;
        s = nw;
        push({MAC, SA[47:32]});
        push({SA[31:0], 16'h0800, 8'h45, 8'h00});
        push({16'd64, 16'h0001, 16'h4000, 8'h40, 8'h11});
        push({16'hBEEF, 32'hC0A8_0063, IP[31:16]});
        push({IP[15:0], 16'h4321, dp, 16'd40});
        push({16'h0000, 48'h0});
        for (int i = 0; i < npay; i++) push(base + 64'(i));
        if (nkeep > 0) nw = s + nkeep;
        frm_last[nw-1] = 1'b1;
        frm_user[nw-1] = user;
    endtask

    task automatic add_arp(input logic [15:0] oper, input logic [47:0] sha,
                           input logic [31:0] spa, input logic [31:0] tpa);
        push({48'hFFFF_FFFF_FFFF, SA[47:32]});
        push({SA[31:0], 16'h0806, 16'h0001});
        push({16'h0800, 8'h06, 8'h04, oper, sha[47:32]});
        push({sha[31:0], spa});
        push({48'h0, tpa[31:16]});
        push({tpa[15:0], 48'h0});
        push(64'h0);
        push(64'h0);
        frm_last[nw-1] = 1'b1;
    endtask

    task automatic send_word(input int i);
        int b;
        b = 0;
        rx_tvalid = 1'b1; rx_tdata = frm[i]; rx_tlast = frm_last[i]; rx_tuser = frm_user[i];
        forever begin
            @(negedge clk);
            if (rx_tready) break;
            b++;
            if (b > 100) begin
                checks++; errors++;
                $display("FAIL send_timeout word %0d: rx_tready stuck 0, required 1", i);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_all(input int upto);
        for (int i = 0; i < upto; i++) send_word(i);
        idle(4);
        nw = 0;
    endtask

    task automatic clear_caps();
        cap1.delete(); cap2.delete(); arp_pulses = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (sm_state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", sm_state); end
        checks++; if (rx_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got %b want 1", rx_tready); end
        checks++; if (rx_pkt_count !== 16'd0 || rx_drop_count !== 16'd0) begin
            errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", rx_pkt_count, rx_drop_count); end
        checks++; if (arp_trigger !== 1'b0 || arp_sender_mac !== 48'h0 || arp_sender_ip !== 32'h0) begin
            errors++; $display("FAIL reset_arp got %b %h %h want 0 0 0", arp_trigger, arp_sender_mac, arp_sender_ip); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_udp_match();
        logic [63:0] got;
        clear_caps();
        add_udp(PORT, 64'h1, 4, 1'b0, 0);
        send_all(nw);
        checks++; if (cap1.size() != 4) begin errors++; $display("FAIL udp_count got %0d want 4", cap1.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < cap1.size()) ? cap1[i] : 64'hx;
            checks++; if (got !== 64'(i + 1)) begin errors++; $display("FAIL udp_word%0d got %h want %h", i, got, 64'(i + 1)); end
        end
        checks++; if (rx_pkt_count !== 16'd1 || rx_drop_count !== 16'd0) begin
            errors++; $display("FAIL udp_counts got %0d/%0d want 1/0", rx_pkt_count, rx_drop_count); end
        checks++; if (sm_state !== 4'd0) begin errors++; $display("FAIL udp_idle got %0d want 0", sm_state); end
    endtask

    task automatic test_wrong_port();
        logic [63:0] got;
        clear_caps();
        add_udp(PORT + 16'd1, 64'h11, 4, 1'b0, 0);
        send_all(nw);
        checks++; if (cap1.size() != 0) begin errors++; $display("FAIL port_fwd got %0d words want 0", cap1.size()); end
        checks++; if (rx_drop_count !== 16'd1) begin errors++; $display("FAIL port_drop got %0d want 1", rx_drop_count); end
        checks++; if (cap2.size() != 4) begin errors++; $display("FAIL anyport_count got %0d want 4", cap2.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < cap2.size()) ? cap2[i] : 64'hx;
            checks++; if (got !== 64'h11 + 64'(i)) begin errors++; $display("FAIL anyport_word%0d got %h want %h", i, got, 64'h11 + 64'(i)); end
        end
        checks++; if (rx_pkt_count2 !== 16'd2) begin errors++; $display("FAIL anyport_pkts got %0d want 2", rx_pkt_count2); end
    endtask

    task automatic test_arp();
        clear_caps();
        add_arp(16'h0001, 48'h0011_2233_4455, 32'h0A00_0001, IP);
        send_all(nw);
        checks++; if (arp_pulses != 1) begin errors++; $display("FAIL arp_pulse got %0d want 1", arp_pulses); end
        checks++; if (arp_sender_mac !== 48'h0011_2233_4455) begin errors++; $display("FAIL arp_mac got %h want 001122334455", arp_sender_mac); end
        checks++; if (arp_sender_ip !== 32'h0A00_0001) begin errors++; $display("FAIL arp_ip got %h want 0a000001", arp_sender_ip); end
        checks++; if (rx_drop_count !== 16'd1) begin errors++; $display("FAIL arp_drop got %0d want 1", rx_drop_count); end
        clear_caps();
        add_arp(16'h0002, 48'h6677_8899_AABB, 32'h0A00_0002, IP);
        send_all(nw);
        checks++; if (arp_pulses != 0) begin errors++; $display("FAIL arp_reply_pulse got %0d want 0", arp_pulses); end
        checks++; if (rx_drop_count !== 16'd2) begin errors++; $display("FAIL arp_reply_drop got %0d want 2", rx_drop_count); end
        checks++; if (arp_sender_mac !== 48'h0011_2233_4455) begin errors++; $display("FAIL arp_reply_mac got %h want 001122334455", arp_sender_mac); end
    endtask

    task automatic test_backpressure();
        logic [63:0] got;
        int low;
        clear_caps();
        low = 0;
        add_udp(PORT, 64'h100, 8, 1'b0, 0);
        for (int i = 0; i < nw; i++) begin
            if (i == 9) begin
                out_ready = 1'b0;
                rx_tvalid = 1'b1; rx_tdata = frm[i]; rx_tlast = frm_last[i]; rx_tuser = frm_user[i];
                repeat (5) begin
                    @(negedge clk);
                    if (!rx_tready) low++;
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
            send_word(i);
        end
        idle(4);
        nw = 0;
        checks++; if (low != 5) begin errors++; $display("FAIL bp_tready_low got %0d cycles want 5", low); end
        checks++; if (cap1.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", cap1.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < cap1.size()) ? cap1[i] : 64'hx;
            checks++; if (got !== 64'h100 + 64'(i)) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, got, 64'h100 + 64'(i)); end
        end
        checks++; if (rx_pkt_count !== 16'd2) begin errors++; $display("FAIL bp_pkts got %0d want 2", rx_pkt_count); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got;
        clear_caps();
        add_udp(PORT, 64'h0, 0, 1'b0, 3);
        add_udp(PORT, 64'h21, 3, 1'b0, 0);
        send_all(nw);
        checks++; if (rx_drop_count !== 16'd3) begin errors++; $display("FAIL trunc_drop got %0d want 3", rx_drop_count); end
        checks++; if (rx_pkt_count !== 16'd3) begin errors++; $display("FAIL trunc_pkts got %0d want 3", rx_pkt_count); end
        checks++; if (cap1.size() != 3) begin errors++; $display("FAIL trunc_count got %0d want 3", cap1.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < cap1.size()) ? cap1[i] : 64'hx;
            checks++; if (got !== 64'h21 + 64'(i)) begin errors++; $display("FAIL trunc_word%0d got %h want %h", i, got, 64'h21 + 64'(i)); end
        end
    endtask

    task automatic test_errored();
        clear_caps();
        add_udp(PORT, 64'h31, 2, 1'b1, 0);
        send_all(nw);
        checks++; if (rx_drop_count !== 16'd4) begin errors++; $display("FAIL err_drop got %0d want 4", rx_drop_count); end
        checks++; if (rx_pkt_count !== 16'd3) begin errors++; $display("FAIL err_pkts got %0d want 3", rx_pkt_count); end
        checks++; if (cap1.size() != 2) begin errors++; $display("FAIL err_fwd got %0d want 2", cap1.size()); end
    endtask

    task automatic test_reset_mid();
        clear_caps();
        add_udp(PORT, 64'h51, 4, 1'b0, 0);
        for (int i = 0; i < 8; i++) send_word(i);
        nw = 0;
        rx_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin
            errors++; $display("FAIL rstmid_out got %b %h want 0 0", out_valid, out_data); end
        checks++; if (sm_state !== 4'd0) begin errors++; $display("FAIL rstmid_state got %0d want 0", sm_state); end
        checks++; if (rx_pkt_count !== 16'd0 || rx_drop_count !== 16'd0) begin
            errors++; $display("FAIL rstmid_counts got %0d/%0d want 0/0", rx_pkt_count, rx_drop_count); end
        checks++; if (arp_sender_mac !== 48'h0 || arp_sender_ip !== 32'h0) begin
            errors++; $display("FAIL rstmid_arp got %h %h want 0 0", arp_sender_mac, arp_sender_ip); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_caps();
        add_udp(PORT, 64'h41, 2, 1'b0, 0);
        send_all(nw);
        checks++; if (cap1.size() != 2 || (cap1.size() == 2 && (cap1[0] !== 64'h41 || cap1[1] !== 64'h42))) begin
            errors++; $display("FAIL rstmid_refwd got %0d words want 2 (41,42)", cap1.size()); end
        checks++; if (rx_pkt_count !== 16'd1) begin errors++; $display("FAIL rstmid_pkts got %0d want 1", rx_pkt_count); end
    endtask

    initial begin
        test_reset();
        test_udp_match();
        test_wrong_port();
        test_arp();
        test_backpressure();
        test_back_to_back();
        test_errored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_rx_parser.md
Name: udp_rx_parser

Overview:
- Receive-side header parser for the UDP offload engine; sits between the Ethernet MAC RX AXI-stream and the RX clock-crossing FIFO toward the kernel.
- Classifies each incoming frame as UDP-for-us, ARP-request-for-us or other.
- Strips Ethernet/IPv4/UDP headers (including the 6-byte header pad) and forwards payload words.
- For a matching ARP request, pulses arp_trigger to the TX stage and latches the requester's MAC and IP.

Parameters:
- CNT_WIDTH, 16, width of packet/drop statistics counters (saturating).
- CHECK_UDP_PORT, 1, when 1 the UDP destination port must equal fpga_udp_port; when 0 any port is accepted.
- ARP_ENABLE, 1, when 0 ARP frames are dropped and arp_trigger stays 0.

Ports:
- clk  in  1  Ethernet RX clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_tvalid  in  1  MAC RX word valid.
- rx_tdata  in  64  MAC RX word; the first wire byte is in [63:56].
- rx_tlast  in  1  last word of frame.
- rx_tuser  in  1  frame error flag, sampled with tlast.
- rx_tready  out  1  backpressure to MAC.
- fpga_mac_adr  in  48  local MAC address.
- fpga_ip_adr  in  32  local IP address.
- fpga_udp_port  in  16  local UDP port.
- out_valid  out  1  payload word valid.
- out_data  out  64  payload word.
- out_ready  in  1  downstream FIFO not full.
- arp_trigger  out  1  one-cycle pulse for a matching ARP request.
- arp_sender_mac  out  48  SHA of the last matching ARP request.
- arp_sender_ip  out  32  SPA of the last matching ARP request.
- rx_pkt_count  out  CNT_WIDTH  accepted UDP frames.
- rx_drop_count  out  CNT_WIDTH  dropped, truncated or errored frames.
- sm_state  out  4  current FSM state encoding.

Behaviour:
- Clocking and reset: one clock domain. rst_n is asynchronous and active-low. All outputs reset to 0 and the FSM resets to IDLE.
- Word layout (word index from frame start):
  - W0: DA[47:0], SA[47:32].
  - W1: SA[31:0], EtherType, then 16 bits.
  - W2: IP len, ID, flags/frag, TTL, proto.
  - W3: IP csum, IP SA, IP DA[31:16].
  - W4: IP DA[15:0], UDP SP, UDP DP, UDP len.
  - W5: UDP csum, 48-bit pad (discarded).
  - W6 onward: payload.
- ARP layout:
  - W1 tail: 0x0806, HTYPE.
  - W2: PTYPE, HLEN, PLEN, OPER, SHA[47:32].
  - W3: SHA[31:0], SPA.
  - W4: THA, TPA[31:16].
  - W5: TPA[15:0].
- FSM states:
  - IDLE: on an rx word (no tlast), check DA == fpga_mac_adr or DA == broadcast; go to HDR1, otherwise to DROP.
  - HDR1: EtherType 0x0800 with tail[15:8] == 0x45 goes to IP2. EtherType 0x0806 with ARP_ENABLE goes to ARP2. Anything else goes to DROP.
  - IP2: proto == 0x11 goes to IP3, otherwise DROP.
  - IP3: no check; go to UDP0.
  - UDP0: IP DA == fpga_ip_adr, and DP == fpga_udp_port if CHECK_UDP_PORT, goes to UDP1; otherwise DROP.
  - UDP1: go to PAYLOAD.
  - PAYLOAD: forward words.
  - ARP2: OPER == 1 goes to ARP3, otherwise DROP.
  - ARP3: latch SHA and SPA into shadow registers; go to ARP4.
  - ARP4: go to ARP5.
  - ARP5: if TPA == fpga_ip_adr, set a match flag; go to ARP_WAIT.
  - ARP_WAIT: at tlast, if the match flag is set and rx_tuser == 0, copy the shadow registers to arp_sender_* and pulse arp_trigger in the same cycle the outputs update. Return to IDLE.
  - DROP: consume words until tlast, then return to IDLE.
- Word advance: all state transitions occur only on a word transfer (rx_tvalid & rx_tready).
- rx_tready:
  - Held at 1 in every state except PAYLOAD.
  - In PAYLOAD it equals (~out_valid | out_ready).
- Output register: single stage, one-cycle latency from accepted rx word to out_valid. out_valid clears when out_ready & ~new word.
- Payload handling: each payload word is forwarded whole; tkeep is not used (word granularity).
- End of packet: tlast in PAYLOAD returns to IDLE. rx_pkt_count increments if rx_tuser == 0; otherwise rx_drop_count increments (data already forwarded is not recalled).
- Truncation: tlast seen in any header state before PAYLOAD or ARP_WAIT returns to IDLE and increments rx_drop_count. A frame that enters DROP increments rx_drop_count once, at its tlast.
- Counters saturate at all-ones.
- Back-to-back frames: a word arriving in IDLE the cycle after tlast is parsed as W0.
- Reset mid-frame: immediately returns to IDLE. The first word seen after reset is treated as W0, with no resynchronisation logic.

Test Plan:
- UDP match: DA = fpga_mac, 0x45, proto 0x11, DP = fpga_udp_port, 4 payload words 0x1..0x4 -> out_data 0x1..0x4 in order, rx_pkt_count = 1, drop count 0.
- Wrong port: DP = fpga_udp_port + 1 with CHECK_UDP_PORT = 1 -> no out_valid, rx_drop_count = 1. Same frame with CHECK_UDP_PORT = 0 -> payload forwarded.
- ARP request: broadcast DA, OPER = 1, TPA = fpga_ip, SHA = 0x0011_2233_4455, SPA = 0x0A00_0001 -> single arp_trigger pulse at tlast, arp_sender_mac/ip equal those values. OPER = 2 -> no pulse, drop count +1.
- Backpressure: out_ready low for 5 cycles mid-payload -> rx_tready low; no word lost or duplicated; order preserved.
- Truncated header: tlast on W2 of an IPv4 frame, followed immediately by a valid UDP frame -> drop count 1, second frame forwarded intact.
- Errored frame: UDP frame with rx_tuser = 1 at tlast -> rx_drop_count +1, rx_pkt_count unchanged. Assert rst_n mid-payload -> all outputs 0, state IDLE.
